// File: rtl/ag_temp_rd_pkg.sv
// Shared definitions for the temp-buffer address generators.
// The write-side generator imports the same depth and address-width helper.
package temp_buf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } rd_state_t;

  localparam int DEFAULT_FEATURE_BITS    = 4;
  localparam int DEFAULT_TEMP_BUFF_DEPTH = 82;
  localparam int DEFAULT_DATA_W          = 16;

  function automatic int addr_w(input int feature_bits);
    return 2 * feature_bits;
  endfunction

endpackage

// File: rtl/ag_temp_rd_if.sv
// DPR read port plus the valid/ready output stream of the temp drain path.
// The master side is the drain controller; the slave side is DPR plus consumer.
interface ag_temp_rd_if
  import temp_buf_pkg::*;
#(
  parameter int FEATURE_BITS = DEFAULT_FEATURE_BITS,
  parameter int DATA_W       = DEFAULT_DATA_W
) ();

  localparam int ADDR_W = addr_w(FEATURE_BITS);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rd_en, rd_addr, out_data, out_valid,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_data, out_valid,
    output rd_data, out_ready
  );

endinterface

// File: rtl/ag_temp_rd_fifo.sv
// Two-entry fall-through skid FIFO: a word arriving into an empty FIFO is
// visible on dout in the same cycle, so the DPR read latency costs no bubble.
module skid_fifo2
  import temp_buf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        cnt,
  output logic              valid
);

  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic [1:0]        cnt_q;

  assign cnt   = cnt_q;
  assign valid = (cnt_q != 2'd0) || push;
  assign dout  = (cnt_q != 2'd0) ? head_q : (push ? din : '0);

  // A pop while empty consumes the word being pushed, so nothing is stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push && !pop) begin
            head_q <= din;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && push) begin
            head_q <= din;
          end else if (pop) begin
            cnt_q <= 2'd0;
          end else if (push) begin
            tail_q <= din;
            cnt_q  <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) tail_q <= din;
            else      cnt_q  <= 2'd1;
          end
        end
      endcase
      assert (!(push && !pop && cnt_q == 2'd2));
    end
  end

endmodule

// File: rtl/ag_temp_rd.sv
// Read-side address generator for the temp output DPR: walks 0..DEPTH-1 once
// per start and streams the words out, gating reads on skid-FIFO credit.
module ag_temp_rd
  import temp_buf_pkg::*;
#(
  parameter int FEATURE_BITS    = DEFAULT_FEATURE_BITS,
  parameter int TEMP_BUFF_DEPTH = DEFAULT_TEMP_BUFF_DEPTH,
  parameter int DATA_W          = DEFAULT_DATA_W
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          start,
  ag_temp_rd_if.master  bus,
  output logic          busy,
  output logic          done
);

  localparam int ADDR_W = addr_w(FEATURE_BITS);
  localparam int XFER_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TEMP_BUFF_DEPTH - 1);
  localparam logic [XFER_W-1:0] LAST_XFER = XFER_W'(TEMP_BUFF_DEPTH - 1);

  rd_state_t         state;
  logic [ADDR_W-1:0] rd_addr;
  logic              inflight;
  logic [XFER_W-1:0] xfer_cnt;
  logic [1:0]        fifo_cnt;
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_dout;
  logic              pop;
  logic              rd_en;
  logic [2:0]        occ;

  // The word in flight from the DPR already owns a FIFO slot; a pop this
  // cycle frees one, which keeps full throughput under steady out_ready.
  assign pop   = fifo_valid && bus.out_ready;
  assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight};
  assign rd_en = (state == READ) && (occ < (3'd2 + {2'b00, pop}));

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_addr;
  assign bus.out_data  = fifo_dout;
  assign bus.out_valid = fifo_valid;

  skid_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk   (sys_clk),
    .reset (reset),
    .push  (inflight),
    .din   (bus.rd_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .cnt   (fifo_cnt),
    .valid (fifo_valid)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state    <= IDLE;
      rd_addr  <= '0;
      inflight <= 1'b0;
      xfer_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (pop) xfer_cnt <= xfer_cnt + XFER_W'(1);
      case (state)
        IDLE: begin
          if (start) begin
            state    <= READ;
            rd_addr  <= '0;
            xfer_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        READ: begin
          if (rd_en) begin
            if (rd_addr == LAST_ADDR) state   <= DRAIN;
            else                      rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (pop && occ == 3'd1) begin
            assert (xfer_cnt == LAST_XFER);
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ag_temp_rd.sv
// Bench for ag_temp_rd: a DEPTH=82 instance fed by a data=addr DPR model and a
// DEPTH=1 instance; outputs are sampled 1ns after each falling clock edge.
module tb_ag_temp_rd;
  import temp_buf_pkg::*;

  localparam int FB    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 82;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  logic start   = 1'b0;
  logic start1  = 1'b0;
  logic busy, done, busy1, done1;

  ag_temp_rd_if #(.FEATURE_BITS(FB), .DATA_W(DW)) bus ();
  ag_temp_rd_if #(.FEATURE_BITS(FB), .DATA_W(DW)) bus1 ();

  ag_temp_rd #(.FEATURE_BITS(FB), .TEMP_BUFF_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  ag_temp_rd #(.FEATURE_BITS(FB), .TEMP_BUFF_DEPTH(1), .DATA_W(DW)) dut1 (
    .sys_clk (sys_clk),
    .reset   (reset),
    .start   (start1),
    .bus     (bus1),
    .busy    (busy1),
    .done    (done1)
  );

  always #5 sys_clk = ~sys_clk;

  // DPR models with one cycle of read latency.
  always @(posedge sys_clk) begin
    if (reset) begin
      bus.rd_data  <= '0;
      bus1.rd_data <= '0;
    end else begin
      if (bus.rd_en)  bus.rd_data  <= DW'(bus.rd_addr);
      if (bus1.rd_en) bus1.rd_data <= 16'h5A00 | DW'(bus1.rd_addr);
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } xfer_t;

  typedef struct {
    int            cyc;
    logic          rd_en;
    logic [7:0]    addr;
    logic          valid;
    logic [DW-1:0] data;
    logic          busy;
    logic          done;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         cycle_no = 0;
  int         rd_cnt = 0;
  int         rd1_cnt = 0;
  int         stab_err = 0;
  logic       held = 1'b0;
  logic [DW-1:0] held_data = '0;
  logic [7:0] rd_addrs[$];
  xfer_t      xfers[$];
  vec_t       vecs[9];

  // One cycle: drive out_ready, then sample and record what the next edge accepts.
  task automatic applyStimulus(input logic rdy);
    @(negedge sys_clk);
    bus.out_ready  = rdy;
    bus1.out_ready = 1'b1;
    #1;
    cycle_no++;
    if (!reset) begin
      if (bus.rd_en) begin
        rd_cnt++;
        rd_addrs.push_back(bus.rd_addr);
      end
      if (bus1.rd_en) rd1_cnt++;
      if (bus.out_valid && bus.out_ready) xfers.push_back('{bus.out_data, cycle_no});
      if (held && (!bus.out_valid || bus.out_data != held_data)) stab_err++;
      held      = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
    end else begin
      held = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic clearLog();
    rd_cnt = 0;
    stab_err = 0;
    held = 1'b0;
    rd_addrs.delete();
    xfers.delete();
  endtask

  // Leave DONE and sit one cycle in IDLE, ready for a fresh start.
  task automatic returnIdle();
    start = 1'b0;
    applyStimulus(1'b1);
    applyStimulus(1'b1);
  endtask

  initial begin
    bus.out_ready  = 1'b1;
    bus1.out_ready = 1'b1;

    // Reset, then a full pass with out_ready held high and start kept high.
    vecs[0] = '{0,  1'b0, 8'd0,  1'b0, 16'd0,  1'b0, 1'b0};
    vecs[1] = '{1,  1'b1, 8'd0,  1'b0, 16'd0,  1'b1, 1'b0};
    vecs[2] = '{2,  1'b1, 8'd1,  1'b1, 16'd0,  1'b1, 1'b0};
    vecs[3] = '{3,  1'b1, 8'd2,  1'b1, 16'd1,  1'b1, 1'b0};
    vecs[4] = '{41, 1'b1, 8'd40, 1'b1, 16'd39, 1'b1, 1'b0};
    vecs[5] = '{82, 1'b1, 8'd81, 1'b1, 16'd80, 1'b1, 1'b0};
    vecs[6] = '{83, 1'b0, 8'd81, 1'b1, 16'd81, 1'b1, 1'b0};
    vecs[7] = '{84, 1'b0, 8'd81, 1'b0, 16'd0,  1'b0, 1'b1};
    vecs[8] = '{90, 1'b0, 8'd81, 1'b0, 16'd0,  1'b0, 1'b1};

    reset = 1'b1;
    repeat (3) applyStimulus(1'b1);
    reset = 1'b0;
    applyStimulus(1'b1);
    clearLog();
    start = 1'b1;
    cycle_no = 0;
    for (int v = 0; v < 9; v++) begin
      while (cycle_no < vecs[v].cyc) applyStimulus(1'b1);
      checkOutput($sformatf("t1_c%0d_rd_en", vecs[v].cyc), bus.rd_en, vecs[v].rd_en);
      checkOutput($sformatf("t1_c%0d_rd_addr", vecs[v].cyc), bus.rd_addr, vecs[v].addr);
      checkOutput($sformatf("t1_c%0d_out_valid", vecs[v].cyc), bus.out_valid, vecs[v].valid);
      checkOutput($sformatf("t1_c%0d_out_data", vecs[v].cyc), bus.out_data, vecs[v].data);
      checkOutput($sformatf("t1_c%0d_busy", vecs[v].cyc), busy, vecs[v].busy);
      checkOutput($sformatf("t1_c%0d_done", vecs[v].cyc), done, vecs[v].done);
    end
    checkOutput("t1_xfer_count", xfers.size(), DEPTH);
    for (int i = 0; i < xfers.size(); i++) begin
      checkOutput($sformatf("t1_xfer%0d_data", i), xfers[i].data, i);
      checkOutput($sformatf("t1_xfer%0d_cycle", i), xfers[i].cyc, i + 2);
    end
    checkOutput("t1_rd_en_count", rd_cnt, DEPTH);

    // start=0 releases DONE; a new pass with out_ready toggling every cycle.
    returnIdle();
    checkOutput("t2_idle_done", done, 1'b0);
    checkOutput("t2_idle_busy", busy, 1'b0);
    clearLog();
    start = 1'b1;
    cycle_no = 0;
    applyStimulus(1'b1);
    checkOutput("t2_first_rd_en", bus.rd_en, 1'b1);
    checkOutput("t2_first_rd_addr", bus.rd_addr, 0);
    begin
      logic rdy;
      rdy = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
        applyStimulus(rdy);
        rdy = ~rdy;
      end
    end
    checkOutput("t2_done_reached", done, 1'b1);
    checkOutput("t2_xfer_count", xfers.size(), DEPTH);
    for (int i = 0; i < xfers.size(); i++)
      checkOutput($sformatf("t2_xfer%0d_data", i), xfers[i].data, i);
    checkOutput("t2_final_rd_addr", bus.rd_addr, DEPTH - 1);
    checkOutput("t2_stability", stab_err, 0);

    // out_ready low for the first 10 cycles, then continuous draining.
    returnIdle();
    clearLog();
    start = 1'b1;
    cycle_no = 0;
    repeat (10) applyStimulus(1'b0);
    checkOutput("t3_rd_en_count", rd_cnt, 2);
    checkOutput("t3_rd_addr0", rd_addrs[0], 0);
    checkOutput("t3_rd_addr1", rd_addrs[1], 1);
    checkOutput("t3_out_valid", bus.out_valid, 1'b1);
    checkOutput("t3_out_data", bus.out_data, 0);
    for (int i = 0; i < 200 && !done; i++) applyStimulus(1'b1);
    checkOutput("t3_done_reached", done, 1'b1);
    checkOutput("t3_xfer_count", xfers.size(), DEPTH);
    for (int i = 0; i < xfers.size(); i++) begin
      checkOutput($sformatf("t3_xfer%0d_data", i), xfers[i].data, i);
      checkOutput($sformatf("t3_xfer%0d_cycle", i), xfers[i].cyc, i + 11);
    end
    checkOutput("t3_stability", stab_err, 0);

    // Reset pulse in the middle of a pass.
    returnIdle();
    clearLog();
    start = 1'b1;
    cycle_no = 0;
    repeat (40) applyStimulus(1'b1);
    checkOutput("t4_busy_mid_pass", busy, 1'b1);
    reset = 1'b1;
    start = 1'b0;
    applyStimulus(1'b1);
    checkOutput("t4_rst_rd_en", bus.rd_en, 1'b0);
    checkOutput("t4_rst_rd_addr", bus.rd_addr, 0);
    checkOutput("t4_rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("t4_rst_out_data", bus.out_data, 0);
    checkOutput("t4_rst_busy", busy, 1'b0);
    checkOutput("t4_rst_done", done, 1'b0);
    reset = 1'b0;
    begin
      int snap;
      snap = rd_cnt;
      repeat (10) applyStimulus(1'b1);
      checkOutput("t4_no_more_rd_en", rd_cnt, snap);
    end
    checkOutput("t4_idle_out_valid", bus.out_valid, 1'b0);
    checkOutput("t4_idle_busy", busy, 1'b0);

    // DEPTH=1 instance: one read, one transfer, done in cycle 3.
    rd1_cnt = 0;
    start1 = 1'b1;
    cycle_no = 0;
    applyStimulus(1'b1);
    checkOutput("t5_c1_rd_en", bus1.rd_en, 1'b1);
    checkOutput("t5_c1_rd_addr", bus1.rd_addr, 0);
    checkOutput("t5_c1_out_valid", bus1.out_valid, 1'b0);
    applyStimulus(1'b1);
    checkOutput("t5_c2_rd_en", bus1.rd_en, 1'b0);
    checkOutput("t5_c2_out_valid", bus1.out_valid, 1'b1);
    checkOutput("t5_c2_out_data", bus1.out_data, 16'h5A00);
    checkOutput("t5_c2_done", done1, 1'b0);
    applyStimulus(1'b1);
    checkOutput("t5_c3_done", done1, 1'b1);
    checkOutput("t5_c3_busy", busy1, 1'b0);
    checkOutput("t5_c3_out_valid", bus1.out_valid, 1'b0);
    start1 = 1'b0;
    repeat (2) applyStimulus(1'b1);
    checkOutput("t5_rd_en_count", rd1_cnt, 1);
    checkOutput("t5_back_idle", done1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ag_temp_rd.md
# ag_temp_rd

Read-side address generator and drain controller for the temp output DPR. The write-side generator fills TEMP_BUFF_DEPTH entries and raises its done flag, which is the start input here. This block then walks the same address space from 0, streams each word out over a valid/ready interface, and absorbs downstream backpressure and the DPR's 1-cycle read latency through a 2-entry skid FIFO. It sits between the systolic array's temp buffer and the downstream consumer (next LSTM stage / output DMA).

## Interface
- FEATURE_BITS, 4: address width is 2*FEATURE_BITS.
- TEMP_BUFF_DEPTH, 82: number of words to read (addresses 0..TEMP_BUFF_DEPTH-1); must be ≤ 2^(2*FEATURE_BITS).
- DATA_W, 16: DPR word width.

- sys_clk  in  1  systolic array clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; write side done. Sampled only in IDLE.
- rd_en  out  1  DPR read enable.
- rd_addr  out  2*FEATURE_BITS  DPR read address.
- rd_data  in  DATA_W  DPR read data; valid exactly 1 cycle after rd_en.
- out_data  out  DATA_W  head of skid FIFO.
- out_valid  out  1  skid FIFO non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- busy  out  1  state is READ or DRAIN.
- done  out  1  high in DONE state.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE → READ when start=1. rd_addr cleared to 0 on entry.
- READ: rd_en = (state==READ) && (fifo_cnt + inflight − pop < 2), where inflight = registered rd_en and pop = out_valid && out_ready. This is a combinational path from out_ready to rd_en by design.
- Each issued read increments rd_addr. The read at TEMP_BUFF_DEPTH−1 moves the FSM to DRAIN. rd_addr holds at TEMP_BUFF_DEPTH−1 and never wraps.
- Returned data (the cycle after rd_en) is pushed into the FIFO unconditionally. The credit rule guarantees the FIFO never overflows; overflow is an assertion failure.
- DRAIN → DONE on the edge that completes the final transfer (inflight=0, fifo_cnt=1, pop=1).
- DONE: done=1, all else idle. DONE → IDLE when start=0. If start stays high, remain in DONE; a new pass requires start to deassert and then reassert.
- Transfer ordering is strictly address order, one word per accepted transfer, exactly TEMP_BUFF_DEPTH transfers per pass.
- Counts are widths: fifo_cnt 2 bits (0..2). The internal transfer counter is 2*FEATURE_BITS+1 bits to hold TEMP_BUFF_DEPTH without overflow.

## Timing
- Reset values: rd_en=0, rd_addr=0, out_valid=0, out_data=0, busy=0, done=0; FSM=IDLE; FIFO empty; inflight=0.
- Reset asserted mid-pass aborts the pass on the next edge. No further rd_en is issued, and in-flight DPR data is discarded.
- start sampled high at edge E0 gives the first rd_en (addr 0) in the cycle after E0.
- out_valid rises 1 cycle after the first rd_en (2 cycles after E0).
- With out_ready held 1, the block sustains one read and one transfer per cycle.
- For DEPTH=82: rd_en is high in cycles 1..82, out_valid in cycles 2..83, and done is first high in cycle 84.
- out_ready=0: at most 2 reads issue beyond the last pop, and rd_en stops. Resumption after out_ready returns to 1 has no bubble.
- out_data/out_valid are stable while out_valid=1 and out_ready=0.

## Structure
- Package temp_buf_pkg:
  - state enum (IDLE/READ/DRAIN/DONE)
  - ADDR_W = 2*FEATURE_BITS helper
  - default TEMP_BUFF_DEPTH, shared with the write-side generator
- Sub-module skid_fifo2:
  - 2-entry, DATA_W-wide FIFO
  - ports: push/din, pop/dout, cnt, valid
  - synchronous active-high reset
- Top contains the FSM, address counter, inflight flop and credit logic.

## Test plan
- Reset, then start=1 with out_ready=1, DEPTH=82, DPR model returning data=addr. Expect 82 transfers of 0..81 in cycles 2..83, done high at cycle 84, rd_addr final=81.
- out_ready toggling 1/0 every cycle. Expect 82 in-order transfers, FIFO never exceeds 2 (assertion), and no duplicate or missing words.
- out_ready=0 for 10 cycles right after start. Expect exactly 2 rd_en pulses (addr 0, 1), out_valid=1 with out_data=0 held stable; after release, continuous transfers with no bubble.
- Reset pulse at cycle 40 mid-pass. Next cycle all outputs are at reset values, and with start low the block stays in IDLE with no further rd_en.
- start held high after done. Expect done stays 1 and no second pass; start=0 returns to IDLE (done=0), and start=1 begins a new pass from addr 0.
- DEPTH=1 parameterization. Expect a single rd_en at addr 0, one transfer, and done 3 cycles after start.
